// File: rtl/ysyx_fetch_unit.sv
// Multi-cycle instruction fetch unit: owns the PC, issues one imem request at a
// time, hands instructions to the IDU and takes EXU redirects with sticky faults.
module ysyx_fetch_unit #(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      INST_W    = 32,
  parameter logic [XLEN-1:0]  RESET_VEC = 32'h8000_0000,
  parameter int unsigned      TIMEOUT   = 64,
  parameter int unsigned      CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  input  logic              imem_resp_err,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [XLEN-1:0]   id_pc,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [XLEN-1:0]   fault_pc,
  output logic [CNT_W-1:0]  fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TMO_LAST = (TIMEOUT == 0) ? '0 : 32'(TIMEOUT - 1);

  localparam logic [1:0] FC_TIMEOUT  = 2'd1;
  localparam logic [1:0] FC_BUS_ERR  = 2'd2;
  localparam logic [1:0] FC_MISALIGN = 2'd3;

  state_t             state, state_d;
  logic [XLEN-1:0]    pc, pc_d;
  logic               kill, kill_d;
  logic [31:0]        timer, timer_d;
  logic [INST_W-1:0]  id_inst_d;
  logic [XLEN-1:0]    id_pc_d;
  logic [1:0]         fault_code_d;
  logic [XLEN-1:0]    fault_pc_d;
  logic [CNT_W-1:0]   fetch_cnt_d;

  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign id_valid       = (state == S_HOLD);
  assign fault          = (state == S_FAULT);

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    kill_d       = kill;
    timer_d      = timer;
    id_inst_d    = id_inst;
    id_pc_d      = id_pc;
    fault_code_d = fault_code;
    fault_pc_d   = fault_pc;
    fetch_cnt_d  = fetch_cnt;

    case (state)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect_valid) pc_d = redirect_pc;
      end
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
          timer_d = '0;
        end
        if (redirect_valid) begin
          pc_d = redirect_pc;
          // Old address already issued: its response must be dropped.
          if (imem_req_ready) kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        timer_d = timer + 32'd1;
        if (imem_resp_valid) begin
          if (kill || redirect_valid) begin
            // Killed response (including a concurrent bus error) is discarded.
            kill_d  = 1'b0;
            state_d = S_REQ;
            if (redirect_valid) pc_d = redirect_pc;
          end else if (imem_resp_err) begin
            state_d      = S_FAULT;
            fault_code_d = FC_BUS_ERR;
            fault_pc_d   = pc;
          end else begin
            id_inst_d = imem_resp_data;
            id_pc_d   = pc;
            state_d   = S_HOLD;
          end
        end else begin
          if (redirect_valid) begin
            pc_d   = redirect_pc;
            kill_d = 1'b1;
          end
          if (TMO_EN && timer == TMO_LAST) begin
            state_d      = S_FAULT;
            fault_code_d = FC_TIMEOUT;
            fault_pc_d   = pc;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (id_ready) begin
          pc_d    = pc + XLEN'(4);
          state_d = S_REQ;
          if (fetch_cnt != '1) fetch_cnt_d = fetch_cnt + CNT_W'(1);
        end
      end
      S_FAULT: ;
      default: state_d = S_FAULT;
    endcase

    // Misaligned redirect overrides every other event in the cycle.
    if (state != S_FAULT && redirect_valid && redirect_pc[1:0] != 2'b00) begin
      state_d      = S_FAULT;
      fault_code_d = FC_MISALIGN;
      fault_pc_d   = redirect_pc;
      pc_d         = pc;
      kill_d       = kill;
      id_inst_d    = id_inst;
      id_pc_d      = id_pc;
      fetch_cnt_d  = fetch_cnt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= RESET_VEC;
      kill       <= 1'b0;
      timer      <= '0;
      id_inst    <= '0;
      id_pc      <= RESET_VEC;
      fault_code <= '0;
      fault_pc   <= '0;
      fetch_cnt  <= '0;
    end else begin
      state      <= state_d;
      pc         <= pc_d;
      kill       <= kill_d;
      timer      <= timer_d;
      id_inst    <= id_inst_d;
      id_pc      <= id_pc_d;
      fault_code <= fault_code_d;
      fault_pc   <= fault_pc_d;
      fetch_cnt  <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_ysyx_fetch_unit.sv
// Directed self-checking bench for ysyx_fetch_unit.
module tb_ysyx_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] fault_pc;
  logic [31:0] fetch_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ysyx_fetch_unit #(
    .XLEN(32), .INST_W(32), .RESET_VEC(32'h8000_0000), .TIMEOUT(64), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .imem_resp_err(imem_resp_err),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fault(fault), .fault_code(fault_code), .fault_pc(fault_pc),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd0);
    chk({tag, "_id_valid"},  64'(id_valid),       64'd0);
    chk({tag, "_id_inst"},   64'(id_inst),        64'd0);
    chk({tag, "_id_pc"},     64'(id_pc),          64'h8000_0000);
    chk({tag, "_fault"},     64'(fault),          64'd0);
    chk({tag, "_fcode"},     64'(fault_code),     64'd0);
    chk({tag, "_fpc"},       64'(fault_pc),       64'd0);
    chk({tag, "_cnt"},       64'(fetch_cnt),      64'd0);
  endtask

  // From REQ: handshake, respond one cycle later, consume immediately.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd1);
    chk({tag, "_req_addr"},  64'(imem_req_addr),  64'(addr));
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk({tag, "_wait_req"}, 64'(imem_req_valid), 64'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    step();
    imem_resp_valid = 1'b0;
    chk({tag, "_id_valid"}, 64'(id_valid), 64'd1);
    chk({tag, "_id_inst"},  64'(id_inst),  64'(data));
    chk({tag, "_id_pc"},    64'(id_pc),    64'(addr));
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    imem_resp_err = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    chk_reset_vals("rst0");
    rst = 1'b0;
    step();

    // Three back-to-back fetches
    do_fetch("f0", 32'h8000_0000, 32'h0000_0013);
    do_fetch("f1", 32'h8000_0004, 32'h0000_0013);
    do_fetch("f2", 32'h8000_0008, 32'h0000_0013);
    chk("cnt3", 64'(fetch_cnt), 64'd3);

    // IDU back-pressure in HOLD
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'hDEAD_BEEF; step(); imem_resp_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 64'(id_valid),       64'd1);
      chk("hold_inst",  64'(id_inst),        64'hDEAD_BEEF);
      chk("hold_pc",    64'(id_pc),          64'h8000_000C);
      chk("hold_noreq", 64'(imem_req_valid), 64'd0);
    end
    id_ready = 1'b1; step(); id_ready = 1'b0;
    chk("hold_cnt",  64'(fetch_cnt),      64'd4);
    chk("hold_req",  64'(imem_req_valid), 64'd1);
    chk("hold_next", 64'(imem_req_addr),  64'h8000_0010);

    // Redirect while WAIT; late response must be dropped
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100; step(); redirect_valid = 1'b0;
    step(); step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1234_5678; step(); imem_resp_valid = 1'b0;
    chk("kill_idv",  64'(id_valid),       64'd0);
    chk("kill_req",  64'(imem_req_valid), 64'd1);
    chk("kill_addr", 64'(imem_req_addr),  64'h8000_0100);
    chk("kill_cnt",  64'(fetch_cnt),      64'd4);

    // Redirect concurrent with id_ready in HOLD
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111; step(); imem_resp_valid = 1'b0;
    chk("rdh_pc", 64'(id_pc), 64'h8000_0100);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0040; id_ready = 1'b1;
    step();
    redirect_valid = 1'b0; id_ready = 1'b0;
    chk("rdh_cnt",  64'(fetch_cnt),      64'd4);
    chk("rdh_idv",  64'(id_valid),       64'd0);
    chk("rdh_addr", 64'(imem_req_addr),  64'h8000_0040);

    // Bus error
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_err = 1'b1; step();
    imem_resp_valid = 1'b0; imem_resp_err = 1'b0;
    chk("berr_fault", 64'(fault),          64'd1);
    chk("berr_code",  64'(fault_code),     64'd2);
    chk("berr_pc",    64'(fault_pc),       64'h8000_0040);
    chk("berr_req",   64'(imem_req_valid), 64'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0006; step(); redirect_valid = 1'b0;
    chk("berr_sticky", 64'(fault_code), 64'd2);
    chk("berr_stkpc",  64'(fault_pc),   64'h8000_0040);

    // Misaligned redirect from REQ
    do_reset();
    chk("mis_req", 64'(imem_req_addr), 64'h8000_0000);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0002; imem_req_ready = 1'b1;
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b0;
    chk("mis_fault", 64'(fault),          64'd1);
    chk("mis_code",  64'(fault_code),     64'd3);
    chk("mis_pc",    64'(fault_pc),       64'h8000_0002);
    chk("mis_req0",  64'(imem_req_valid), 64'd0);

    // Timeout with no response
    do_reset();
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    for (int i = 0; i < 63; i++) step();
    chk("tmo_early", 64'(fault), 64'd0);
    step();
    chk("tmo_fault", 64'(fault),      64'd1);
    chk("tmo_code",  64'(fault_code), 64'd1);
    chk("tmo_pc",    64'(fault_pc),   64'h8000_0000);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("tmo_noreq", 64'(imem_req_valid), 64'd0);
    end
    imem_req_ready = 1'b0;

    // Async reset mid-WAIT, stray response afterwards
    do_reset();
    imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_vals("rstw");
    step();
    rst = 1'b0;
    step();
    imem_resp_valid = 1'b1; imem_resp_data = 32'hBAD0_BAD0; step(); imem_resp_valid = 1'b0;
    chk("stray_idv",  64'(id_valid),       64'd0);
    chk("stray_req",  64'(imem_req_valid), 64'd1);
    chk("stray_inst", 64'(id_inst),        64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
